digit_serial_subtractor: RTL and testbench



---
 rtl/digit_serial_subtractor.sv | 111 +++++++++++
 tb/tb_digit_serial_subtractor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_subtractor.sv
// Two's-complement subtractor A - B, two bits per clock using carry-select digit slices.
// Latency WIDTH/2 cycles from accepted start to done; start is ignored while busy.
module digit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [2:0]       w_sum_c0;
  logic [2:0]       w_sum_c1;
  logic [2:0]       w_slice;
  logic [WIDTH+1:0] w_cat;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == CW'(N - 1));

  // Both carry-in cases are evaluated up front; the registered carry only drives the mux.
  assign w_sum_c0   = {1'b0, r_a[1:0]} + {1'b0, r_b[1:0]};
  assign w_sum_c1   = {1'b0, r_a[1:0]} + {1'b0, r_b[1:0]} + 3'd1;
  assign w_slice    = r_carry ? w_sum_c1 : w_sum_c0;
  assign w_cat      = {w_slice[1:0], r_res};
  assign w_res_next = w_cat[WIDTH+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= ~b;
        r_carry <= 1'b1;
        r_cnt   <= '0;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end else if (r_state == RUN) begin
        r_a     <= r_a >> 2;
        r_b     <= r_b >> 2;
        r_res   <= w_res_next;
        r_carry <= w_slice[2];
        r_cnt   <= r_cnt + 1'b1;
      end
      // Visible results change only on the final digit, so they hold across the next run.
      if ((r_state == RUN) && w_last) begin
        r_diff   <= w_res_next;
        r_borrow <= ~w_slice[2];
        r_ovf    <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor at WIDTH 8 (directed), 2 and 16 (random vs arithmetic model).
module tb_digit_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: WIDTH=8, 1: WIDTH=2, 2: WIDTH=16
  logic        st [3];
  logic [15:0] av [3];
  logic [15:0] bv [3];
  logic        bz [3];
  logic        dn [3];
  logic        bo [3];
  logic        ov [3];
  logic [15:0] df [3];
  logic [7:0]  df8;
  logic [1:0]  df2;
  logic [15:0] df16;

  digit_serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
    .busy(bz[0]), .done(dn[0]), .diff(df8), .borrow(bo[0]), .ovf(ov[0]));
  digit_serial_subtractor #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][1:0]), .b(bv[1][1:0]),
    .busy(bz[1]), .done(dn[1]), .diff(df2), .borrow(bo[1]), .ovf(ov[1]));
  digit_serial_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]),
    .busy(bz[2]), .done(dn[2]), .diff(df16), .borrow(bo[2]), .ovf(ov[2]));

  assign df[0] = {8'h00, df8};
  assign df[1] = {14'h0, df2};
  assign df[2] = df16;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic ref_sub(input int w, input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] d, output logic bw, output logic of);
    longint m, ua, ub, sa, sb, sd, half;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(ia) & m;
    ub   = longint'(ib) & m;
    d    = 16'((ua - ub) & m);
    bw   = (ua < ub);
    sa   = (ua >= half) ? ua - (half * 2) : ua;
    sb   = (ub >= half) ? ub - (half * 2) : ub;
    sd   = sa - sb;
    of   = (sd > half - 1) || (sd < -half);
  endtask

  // Start one operation on DUT sel; DUT must be in IDLE or DONE.
  task automatic run_op(input int sel, input int w, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] ed, input logic eb, input logic eo, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    st[sel] = 1'b1;
    av[sel] = ia;
    bv[sel] = ib;
    @(posedge clk);
    #1;
    st[sel] = 1'b0;
    av[sel] = 16'($urandom);
    bv[sel] = 16'($urandom);
    chk({tag, " busy_after_accept"}, bz[sel], 1);
    seen = 0;
    lat = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (dn[sel]) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, lat);
    end else begin
      chk({tag, " latency"}, lat, w / 2);
      chk({tag, " busy_in_done"}, bz[sel], 0);
      chk({tag, " diff"}, df[sel], ed);
      chk({tag, " borrow"}, bo[sel], eb);
      chk({tag, " ovf"}, ov[sel], eo);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bw;
    logic       of;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [15:0] rd;
    logic rb, ro;
    logic [15:0] ra, rbv;
    int cnt;
    int dpos [$];
    int viol;

    tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    tbl[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h09, 8'h0A, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      av[i] = '0;
      bv[i] = '0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset busy", bz[i], 0);
      chk("reset done", dn[i], 0);
      chk("reset diff", df[i], 0);
      chk("reset borrow", bo[i], 0);
      chk("reset ovf", ov[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk);

    // Directed table at WIDTH=8
    foreach (tbl[i]) run_op(0, 8, {8'h0, tbl[i].a}, {8'h0, tbl[i].b}, {8'h0, tbl[i].d},
                            tbl[i].bw, tbl[i].of, "w8_table");
    repeat (2) @(posedge clk);

    // Start pulsed while busy with different operands: ignored, exactly one done
    @(negedge clk);
    st[0] = 1'b1; av[0] = 16'h5A; bv[0] = 16'h3C;
    @(posedge clk);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      st[0] = bz[0];
      av[0] = 16'hFF;
      bv[0] = 16'h01;
      if (dn[0]) cnt++;
    end
    st[0] = 1'b0;
    chk("busy_start_done_count", cnt, 1);
    chk("busy_start_diff", df[0], 16'h1E);
    chk("busy_start_borrow", bo[0], 0);

    // Start held high: done every 5th cycle, busy low only in done cycles
    @(negedge clk);
    st[0] = 1'b1; av[0] = 16'h05; bv[0] = 16'h03;
    @(posedge clk);
    viol = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      if (dn[0]) begin
        dpos.push_back(c);
        if (df[0] != 16'h02) viol++;
      end
      if (bz[0] == dn[0]) viol++;
    end
    st[0] = 1'b0;
    chk("held_done_count", dpos.size(), 3);
    if (dpos.size() == 3) begin
      chk("held_first_done", dpos[0], 4);
      chk("held_spacing1", dpos[1] - dpos[0], 5);
      chk("held_spacing2", dpos[2] - dpos[1], 5);
    end
    chk("held_busy_done_diff_violations", viol, 0);
    cnt = 0;
    while (!dn[0] && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    repeat (2) @(posedge clk);

    // Reset during the 2nd RUN cycle aborts the operation
    @(negedge clk);
    st[0] = 1'b1; av[0] = 16'h5A; bv[0] = 16'h3C;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort busy", bz[0], 0);
    chk("abort done", dn[0], 0);
    chk("abort diff", df[0], 0);
    chk("abort borrow", bo[0], 0);
    chk("abort ovf", ov[0], 0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (dn[0] || bz[0]) cnt++;
    end
    chk("abort no_activity", cnt, 0);
    run_op(0, 8, 16'h09, 16'h0A, 16'hFF, 1'b1, 1'b0, "after_abort");

    // Random against the arithmetic model at WIDTH=2 and WIDTH=16
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom_range(0, 3));
      rbv = 16'($urandom_range(0, 3));
      ref_sub(2, ra, rbv, rd, rb, ro);
      run_op(1, 2, ra, rbv, rd, rb, ro, "w2_rand");
    end
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rbv = 16'($urandom);
      if (i % 8 == 0) rbv = ra;
      if (i % 8 == 1) ra = 16'h8000;
      ref_sub(16, ra, rbv, rd, rb, ro);
      run_op(2, 16, ra, rbv, rd, rb, ro, "w16_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
